// File: rtl/ni_crc32_scheduler_pkg.sv
//------------------------------------------------------------------------------
// ni_crc32_scheduler_pkg
// Shared constants, slot classification and width helper for the CRC32
// scheduler slice.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ni_crc32_scheduler_pkg;

   localparam int          CRC_W             = 32;
   localparam logic [31:0] FINAL_XOR_DEFAULT = 32'h0000_0000;

   // What the single shared engine slot is used for in a given cycle
   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_WORD = 2'd1,
      SLOT_READ = 2'd2
   } slot_kind_e;

   // Index width for n entries; never below one bit so CHANNEL=1 still has a port
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ni_crc32_scheduler_if.sv
//------------------------------------------------------------------------------
// ni_crc32_scheduler_if
// Bundles the requester handshake, the engine control/data path and the
// result reporting of the CRC32 scheduler.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ni_crc32_scheduler_if #(
   parameter int CHANNEL = 4
);
   import ni_crc32_scheduler_pkg::*;

   localparam int CHW = clog2_min1(CHANNEL);

   // Requester side
   logic [CHANNEL-1:0]       req_valid;
   logic [CHANNEL-1:0]       req_last;
   logic [CHANNEL*CRC_W-1:0] req_data;
   logic [CHANNEL-1:0]       req_ready;

   // Engine side
   logic [CHW-1:0]           crc_channel;
   logic                     crc_reset;
   logic                     crc_enable;
   logic [CRC_W-1:0]         crc_data;
   logic [CRC_W-1:0]         crc_in;

   // Result reporting
   logic                     crc_done;
   logic [CHW-1:0]           crc_done_ch;
   logic [CRC_W-1:0]         crc_result;
   logic                     busy;

   // Requesters plus engine, seen from outside the scheduler
   modport master (
      output req_valid, req_last, req_data, crc_in,
      input  req_ready, crc_channel, crc_reset, crc_enable, crc_data,
      input  crc_done, crc_done_ch, crc_result, busy
   );

   // The scheduler itself
   modport slave (
      input  req_valid, req_last, req_data, crc_in,
      output req_ready, crc_channel, crc_reset, crc_enable, crc_data,
      output crc_done, crc_done_ch, crc_result, busy
   );

endinterface

`default_nettype wire

// File: rtl/ni_crc_rr_arbiter.sv
//------------------------------------------------------------------------------
// ni_crc_rr_arbiter
// Combinational round-robin arbiter: first requesting index at or after the
// pointer, wrapping, as a one-hot grant plus encoded index.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ni_crc_rr_arbiter #(
   parameter int CHANNEL = 4,
   parameter int CHW     = 2
) (
   input  wire logic [CHANNEL-1:0] req,
   input  wire logic [CHW-1:0]     ptr,
   output logic      [CHANNEL-1:0] grant,
   output logic      [CHW-1:0]     idx,
   output logic                    any
);

   int cand;

   // Scan from the farthest offset down so the nearest requester overwrites
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = CHANNEL - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % CHANNEL;
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            idx         = CHW'(cand);
            any         = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ni_crc32_scheduler.sv
//------------------------------------------------------------------------------
// ni_crc32_scheduler
// Time-shares one multi-channel CRC32 engine among CHANNEL requesters: each
// cycle one round-robin slot is either a data word or a read-and-clear of a
// finished packet's CRC.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ni_crc32_scheduler
   import ni_crc32_scheduler_pkg::*;
#(
   parameter int               CHANNEL   = 4,
   parameter logic [CRC_W-1:0] FINAL_XOR = FINAL_XOR_DEFAULT
) (
   input  wire logic           clk,
   input  wire logic           reset_n,
   ni_crc32_scheduler_if.slave bus
);

   localparam int CHW = clog2_min1(CHANNEL);

   logic [CHW-1:0]     rr_ptr;
   logic [CHW-1:0]     next_ptr;
   logic [CHANNEL-1:0] pending_read;
   logic [CHANNEL-1:0] req_vec;
   logic [CHANNEL-1:0] grant;
   logic [CHW-1:0]     win_idx;
   logic               win_any;
   slot_kind_e         slot;

   logic               done_q;
   logic [CHW-1:0]     done_ch_q;
   logic [CRC_W-1:0]   result_q;

   // A channel with a finished packet keeps competing until its CRC is read out
   assign req_vec = pending_read | bus.req_valid;

   ni_crc_rr_arbiter #(
      .CHANNEL (CHANNEL),
      .CHW     (CHW)
   ) u_arb (
      .req   (req_vec),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // Classify the slot: a pending read always takes priority over new words
   always_comb begin
      slot = SLOT_IDLE;
      if (win_any) begin
         slot = pending_read[win_idx] ? SLOT_READ : SLOT_WORD;
      end
   end

   // Drive engine controls and the requester handshake for the current slot
   always_comb begin
      bus.req_ready   = '0;
      bus.crc_channel = rr_ptr;
      bus.crc_enable  = 1'b0;
      bus.crc_reset   = 1'b0;
      bus.crc_data    = '0;
      case (slot)
         SLOT_WORD: begin
            bus.req_ready   = grant;
            bus.crc_channel = win_idx;
            bus.crc_enable  = 1'b1;
            bus.crc_data    = bus.req_data[CRC_W*int'(win_idx) +: CRC_W];
         end
         SLOT_READ: begin
            bus.crc_channel = win_idx;
            bus.crc_reset   = 1'b1;
         end
         default: ;
      endcase
   end

   // Pointer moves one past whoever won so the winner goes to the back of the line
   always_comb begin
      next_ptr = rr_ptr;
      if (win_any) begin
         next_ptr = (win_idx == CHW'(CHANNEL - 1)) ? '0 : win_idx + CHW'(1);
      end
   end

   // Round-robin pointer and per-channel "CRC ready to read" flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr       <= '0;
         pending_read <= '0;
      end else begin
         rr_ptr <= next_ptr;
         if (slot == SLOT_WORD && bus.req_last[win_idx]) begin
            pending_read[win_idx] <= 1'b1;
         end else if (slot == SLOT_READ) begin
            pending_read[win_idx] <= 1'b0;
         end
      end
   end

   // Capture the engine CRC on a read slot; result is held until the next read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_q    <= 1'b0;
         done_ch_q <= '0;
         result_q  <= '0;
      end else begin
         done_q <= (slot == SLOT_READ);
         if (slot == SLOT_READ) begin
            done_ch_q <= win_idx;
            result_q  <= bus.crc_in ^ FINAL_XOR;
         end
      end
   end

   assign bus.crc_done    = done_q;
   assign bus.crc_done_ch = done_ch_q;
   assign bus.crc_result  = result_q;
   assign bus.busy        = |pending_read;

endmodule

`default_nettype wire

// File: tb/tb_ni_crc32_scheduler.sv
//------------------------------------------------------------------------------
// tb_ni_crc32_scheduler
// Directed bench for the CRC32 scheduler. Two instances share clock/reset:
// dut_a with FINAL_XOR=0, dut_b with FINAL_XOR=all ones. Each has a small
// behavioural multi-channel CRC32 engine attached.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ni_crc32_scheduler;

   logic clk;
   logic reset_n;
   int   checks;
   int   passed;

   ni_crc32_scheduler_if #(.CHANNEL(4)) bus_a ();
   ni_crc32_scheduler_if #(.CHANNEL(4)) bus_b ();

   ni_crc32_scheduler #(.CHANNEL(4), .FINAL_XOR(32'h0000_0000)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_a.slave)
   );

   ni_crc32_scheduler #(.CHANNEL(4), .FINAL_XOR(32'hFFFF_FFFF)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // MSB-first CRC32 (poly 04C11DB7) of one 32-bit word
   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] d);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int b = 31; b >= 0; b--) begin
         fb = c[31] ^ d[b];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ 32'h04C1_1DB7;
      end
      return c;
   endfunction

   // Engine models sharing the scheduler reset
   logic [31:0] eng_a [4];
   logic [31:0] eng_b [4];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) eng_a[i] <= '0;
      end else if (bus_a.crc_reset) begin
         eng_a[bus_a.crc_channel] <= '0;
      end else if (bus_a.crc_enable) begin
         eng_a[bus_a.crc_channel] <= crc_step(eng_a[bus_a.crc_channel], bus_a.crc_data);
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) eng_b[i] <= '0;
      end else if (bus_b.crc_reset) begin
         eng_b[bus_b.crc_channel] <= '0;
      end else if (bus_b.crc_enable) begin
         eng_b[bus_b.crc_channel] <= crc_step(eng_b[bus_b.crc_channel], bus_b.crc_data);
      end
   end

   assign bus_a.crc_in = eng_a[bus_a.crc_channel];
   assign bus_b.crc_in = eng_b[bus_b.crc_channel];

   task automatic clear_inputs();
      bus_a.req_valid = '0;
      bus_a.req_last  = '0;
      bus_a.req_data  = '0;
      bus_b.req_valid = '0;
      bus_b.req_last  = '0;
      bus_b.req_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus_a.crc_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus_a.crc_done);
      else passed++;
      checks++;
      if (bus_a.crc_result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", bus_a.crc_result);
      else passed++;
      checks++;
      if (bus_a.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_a.busy);
      else passed++;
      checks++;
      if (bus_a.req_ready !== 4'b0000 || bus_a.crc_enable !== 1'b0 || bus_a.crc_reset !== 1'b0)
         $display("FAIL reset_idle: ready %b en %b rst %b expected 0000 0 0",
                  bus_a.req_ready, bus_a.crc_enable, bus_a.crc_reset);
      else passed++;
      reset_n = 1'b1;
   endtask

   task automatic test_single_word();
      do_reset();
      // word slot
      bus_a.req_valid = 4'b0001;
      bus_a.req_last  = 4'b0001;
      bus_a.req_data[31:0] = 32'h1;
      #1;
      checks++;
      if (bus_a.req_ready !== 4'b0001 || bus_a.crc_enable !== 1'b1 || bus_a.crc_channel !== 2'd0 || bus_a.crc_data !== 32'h1)
         $display("FAIL single_word_slot: ready %b en %b ch %0d data %h expected 0001 1 0 00000001",
                  bus_a.req_ready, bus_a.crc_enable, bus_a.crc_channel, bus_a.crc_data);
      else passed++;
      // read slot
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if (bus_a.crc_reset !== 1'b1 || bus_a.crc_channel !== 2'd0 || bus_a.req_ready !== 4'b0000 || bus_a.busy !== 1'b1)
         $display("FAIL single_read_slot: rst %b ch %0d ready %b busy %b expected 1 0 0000 1",
                  bus_a.crc_reset, bus_a.crc_channel, bus_a.req_ready, bus_a.busy);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (bus_a.crc_done !== 1'b1 || bus_a.crc_done_ch !== 2'd0 || bus_a.crc_result !== 32'h04C11DB7)
         $display("FAIL single_result: done %b ch %0d result %h expected 1 0 04c11db7",
                  bus_a.crc_done, bus_a.crc_done_ch, bus_a.crc_result);
      else passed++;
      checks++;
      if (bus_a.busy !== 1'b0) $display("FAIL single_busy_clear: got %b expected 0", bus_a.busy);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (bus_a.crc_done !== 1'b0 || bus_a.crc_result !== 32'h04C11DB7)
         $display("FAIL single_done_pulse: done %b result %h expected 0 04c11db7",
                  bus_a.crc_done, bus_a.crc_result);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [3:0]  exp_ready [8];
      logic        exp_rst   [8];
      logic        exp_done  [8];
      logic [1:0]  exp_dch   [8];
      logic [31:0] exp_res   [8];
      int          cnt [2];
      logic [3:0]  rdy;
      exp_ready = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
      exp_rst   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_done  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_dch   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      exp_res   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h04C11DB7, 32'h09823B6E};
      cnt[0] = 0;
      cnt[1] = 0;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c != 0) @(negedge clk);
         // ch0 packet {0,0,1}, ch1 packet {0,0,2}
         for (int ch = 0; ch < 2; ch++) begin
            bus_a.req_valid[ch] = (cnt[ch] < 3);
            bus_a.req_last[ch]  = (cnt[ch] == 2);
            bus_a.req_data[32*ch +: 32] = (cnt[ch] == 2) ? ((ch == 0) ? 32'h1 : 32'h2) : 32'h0;
         end
         #1;
         rdy = bus_a.req_ready;
         checks++;
         if (rdy !== exp_ready[c]) $display("FAIL b2b_ready[%0d]: got %b expected %b", c, rdy, exp_ready[c]);
         else passed++;
         checks++;
         if (bus_a.crc_reset !== exp_rst[c] || bus_a.crc_channel !== 2'(c % 2))
            $display("FAIL b2b_slot[%0d]: rst %b ch %0d expected %b %0d", c, bus_a.crc_reset,
                     bus_a.crc_channel, exp_rst[c], c % 2);
         else passed++;
         @(posedge clk);
         for (int ch = 0; ch < 2; ch++) if (rdy[ch]) cnt[ch]++;
         #1;
         checks++;
         if (bus_a.crc_done !== exp_done[c]) $display("FAIL b2b_done[%0d]: got %b expected %b", c, bus_a.crc_done, exp_done[c]);
         else passed++;
         if (exp_done[c]) begin
            checks++;
            if (bus_a.crc_done_ch !== exp_dch[c] || bus_a.crc_result !== exp_res[c])
               $display("FAIL b2b_result[%0d]: ch %0d result %h expected %0d %h", c,
                        bus_a.crc_done_ch, bus_a.crc_result, exp_dch[c], exp_res[c]);
            else passed++;
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_pending_blocks();
      do_reset();
      // ch1 single-word packet, data 1
      bus_a.req_valid = 4'b0010;
      bus_a.req_last  = 4'b0010;
      bus_a.req_data[63:32] = 32'h1;
      @(negedge clk);
      // next packet word 3 offered while ch1 still owes a read
      bus_a.req_data[63:32] = 32'h3;
      #1;
      checks++;
      if (bus_a.req_ready !== 4'b0000 || bus_a.crc_reset !== 1'b1 || bus_a.crc_channel !== 2'd1)
         $display("FAIL pend_read_slot: ready %b rst %b ch %0d expected 0000 1 1",
                  bus_a.req_ready, bus_a.crc_reset, bus_a.crc_channel);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if (bus_a.crc_done !== 1'b1 || bus_a.crc_done_ch !== 2'd1 || bus_a.crc_result !== 32'h04C11DB7)
         $display("FAIL pend_first_result: done %b ch %0d result %h expected 1 1 04c11db7",
                  bus_a.crc_done, bus_a.crc_done_ch, bus_a.crc_result);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (bus_a.req_ready !== 4'b0010 || bus_a.crc_enable !== 1'b1 || bus_a.crc_data !== 32'h3)
         $display("FAIL pend_word_accept: ready %b en %b data %h expected 0010 1 00000003",
                  bus_a.req_ready, bus_a.crc_enable, bus_a.crc_data);
      else passed++;
      @(negedge clk);
      clear_inputs();
      @(posedge clk);
      #1;
      checks++;
      if (bus_a.crc_done !== 1'b1 || bus_a.crc_done_ch !== 2'd1 || bus_a.crc_result !== 32'h0D4326D9)
         $display("FAIL pend_second_result: done %b ch %0d result %h expected 1 1 0d4326d9",
                  bus_a.crc_done, bus_a.crc_done_ch, bus_a.crc_result);
      else passed++;
   endtask

   task automatic test_mid_packet_reset();
      do_reset();
      // ch3 single word -> nonzero result and done_ch
      bus_a.req_valid = 4'b1000;
      bus_a.req_last  = 4'b1000;
      bus_a.req_data[127:96] = 32'h1;
      #1;
      checks++;
      if (bus_a.req_ready !== 4'b1000) $display("FAIL mid_ch3_ready: got %b expected 1000", bus_a.req_ready);
      else passed++;
      @(negedge clk);
      clear_inputs();
      @(posedge clk);
      #1;
      checks++;
      if (bus_a.crc_done_ch !== 2'd3 || bus_a.crc_result !== 32'h04C11DB7)
         $display("FAIL mid_ch3_result: ch %0d result %h expected 3 04c11db7", bus_a.crc_done_ch, bus_a.crc_result);
      else passed++;
      // ch1 finishes (left pending), ch2 starts a multi-word packet
      @(negedge clk);
      bus_a.req_valid = 4'b0110;
      bus_a.req_last  = 4'b0010;
      bus_a.req_data[63:32] = 32'h1;
      bus_a.req_data[95:64] = 32'h5;
      @(negedge clk);
      bus_a.req_valid = 4'b0100;
      bus_a.req_last  = 4'b0000;
      #1;
      checks++;
      if (bus_a.req_ready !== 4'b0100) $display("FAIL mid_ch2_ready: got %b expected 0100", bus_a.req_ready);
      else passed++;
      @(negedge clk);
      clear_inputs();
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus_a.crc_done_ch !== 2'd0 || bus_a.crc_result !== 32'h0 || bus_a.busy !== 1'b0 || bus_a.crc_channel !== 2'd0)
         $display("FAIL mid_reset_state: ch %0d result %h busy %b ptr %0d expected 0 00000000 0 0",
                  bus_a.crc_done_ch, bus_a.crc_result, bus_a.busy, bus_a.crc_channel);
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      bus_a.req_valid = 4'b0100;
      bus_a.req_last  = 4'b0100;
      bus_a.req_data[95:64] = 32'h1;
      @(negedge clk);
      clear_inputs();
      @(posedge clk);
      #1;
      checks++;
      if (bus_a.crc_done !== 1'b1 || bus_a.crc_done_ch !== 2'd2 || bus_a.crc_result !== 32'h04C11DB7)
         $display("FAIL mid_after_reset_result: done %b ch %0d result %h expected 1 2 04c11db7",
                  bus_a.crc_done, bus_a.crc_done_ch, bus_a.crc_result);
      else passed++;
   endtask

   task automatic test_fairness();
      logic [3:0]  exp_ready [8];
      logic [31:0] exp_data  [8];
      exp_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_data  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
      do_reset();
      bus_a.req_valid = 4'b1111;
      bus_a.req_last  = 4'b0000;
      bus_a.req_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      for (int c = 0; c < 8; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         checks++;
         if (bus_a.req_ready !== exp_ready[c] || bus_a.crc_data !== exp_data[c])
            $display("FAIL fair[%0d]: ready %b data %h expected %b %h", c,
                     bus_a.req_ready, bus_a.crc_data, exp_ready[c], exp_data[c]);
         else passed++;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_final_xor();
      do_reset();
      bus_b.req_valid = 4'b1000;
      bus_b.req_last  = 4'b1000;
      bus_b.req_data[127:96] = 32'h1;
      #1;
      checks++;
      if (bus_b.req_ready !== 4'b1000) $display("FAIL xor_ready: got %b expected 1000", bus_b.req_ready);
      else passed++;
      @(negedge clk);
      clear_inputs();
      @(posedge clk);
      #1;
      checks++;
      if (bus_b.crc_done !== 1'b1 || bus_b.crc_done_ch !== 2'd3 || bus_b.crc_result !== 32'hFB3EE248)
         $display("FAIL xor_result: done %b ch %0d result %h expected 1 3 fb3ee248",
                  bus_b.crc_done, bus_b.crc_done_ch, bus_b.crc_result);
      else passed++;
   endtask

   initial begin
      checks  = 0;
      passed  = 0;
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_pending_blocks();
      test_mid_packet_reset();
      test_fairness();
      test_final_xor();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
